// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch: four byte beats over a req/ack port, one-cycle valid to IF/ID
// Fetch starts from IDLE on chipEnable and returns to IDLE on the final beat, a flush or reset.
module inst_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chipEnable,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic              stall_if
);

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base;
  logic [1:0]        byte_cnt;
  logic [23:0]       shift_buf;
  logic              start;
  logic              beat_done;
  logic              last_beat;

  // Beat address wraps naturally modulo 2^ADDR_W.
  assign mem_addr = base + ADDR_W'(byte_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    stall_if  = 1'b0;
    start     = 1'b0;
    beat_done = 1'b0;
    last_beat = 1'b0;
    case (state)
      IDLE: begin
        // A flush here lets the PC register load the branch target instead.
        if (chipEnable && !flush) begin
          stall_if  = 1'b1;
          start     = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        mem_req   = 1'b1;
        beat_done = mem_ack && !flush;
        last_beat = beat_done && (byte_cnt == 2'd3);
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          // Release the PC register on the edge that completes the word.
          stall_if = !last_beat;
          if (last_beat) begin
            state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base       <= '0;
      byte_cnt   <= '0;
      shift_buf  <= '0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
    end else begin
      inst_valid <= last_beat;
      if (start) begin
        base      <= pc;
        byte_cnt  <= '0;
        shift_buf <= '0;
      end
      if (beat_done) begin
        byte_cnt  <= byte_cnt + 2'd1;
        // Shifting in from the top leaves bytes 0..2 in little-endian order.
        shift_buf <= {mem_rdata, shift_buf[23:8]};
      end
      if (last_beat) begin
        inst    <= INST_W'({mem_rdata, shift_buf});
        inst_pc <= base;
      end
    end
  end

endmodule
